mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage initiator for the word-wide Memory responder (ren/wen/addr/din/dout).
//  Accepts load/store requests from the pipeline and drives the memory port with ren/wen mutually exclusive.
//  Performs byte/halfword loads with sign/zero extension, and sub-word stores by read-modify-write.
//  Returns one response per request.
// PARAMETERS
//  BIG_ENDIAN  1  1: byte offset 0 = bits[31:24] (MIPS); 0: byte offset 0 = bits[7:0]
//  WORD_AW     10 width of word index driven on mem_addr (upper mem_addr bits forced 0)
// PORTS
//  clock      in   1   system clock; all state on posedge
//  reset      in   1   reset, asynchronous, active-low
//  req_valid  in   1   request present
//  req_ready  out  1   1 = unit idle; request accepted on posedge when valid & ready
//  req_we     in   1   1 = store, 0 = load
//  req_size   in   2   0 = byte, 1 = half, 2 = word; 3 treated as word
//  req_signed in   1   loads: sign-extend sub-word data
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data, right-aligned for sub-word stores
//  rsp_valid  out  1   one-cycle pulse: load data valid or store done; no backpressure
//  rsp_rdata  out  32  extended load data; 0 for stores
//  rsp_err    out  1   misaligned request, qualified by rsp_valid
//  mem_ren    out  1   memory read enable
//  mem_wen    out  1   memory write enable (Memory commits on the following negedge)
//  mem_addr   out  32  word index = req_addr[WORD_AW+1:2]
//  mem_din    out  32  write data
//  mem_dout   in   32  read data, combinational from Memory
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE; req_ready=1; rsp_valid=0, rsp_err=0, rsp_rdata=0;
//   mem_ren=0, mem_wen=0, mem_addr=0, mem_din=0. Applies immediately, including mid-access.
//  mem_ren and mem_wen are decoded from the registered state, so they are glitch-free.
//   They are never 1 together.
//  FSM states: IDLE, RD, WR, RMW_RD, RMW_WR.
//   IDLE on accept:
//    - load -> RD.
//    - word store -> WR.
//    - sub-word store -> RMW_RD.
//    - misaligned -> IDLE with response next cycle.
//    Request fields are latched in all cases.
//   RD: mem_ren=1. At the next posedge, capture mem_dout, extract the lane, extend it,
//    pulse rsp_valid, and go to IDLE.
//   WR: mem_wen=1, mem_din=wdata. At the next posedge, pulse rsp_valid and go to IDLE.
//   RMW_RD: mem_ren=1. At posedge, merge the wdata lane into mem_dout, register it into mem_din,
//    and go to RMW_WR.
//   RMW_WR: mem_wen=1. At posedge, pulse rsp_valid and go to IDLE.
//  Latency, accept edge to rsp_valid edge: load 2, word store 2, sub-word store 3, misaligned 1.
//  req_ready=1 only in IDLE, including the cycle rsp_valid is high. Back-to-back accepts are allowed.
//  Requests arriving while busy are not accepted; the requester holds them.
//  Lanes:
//   - byte lane = addr[1:0]; half lane = addr[1].
//   - BIG_ENDIAN=1: byte 0 -> [31:24], half 0 -> [31:16].
//   - Store merge replaces only the selected lane. Other bytes come from the read word.
//  Misaligned: half with addr[0]=1, or word with addr[1:0]!=0 (see CONFIGURATION).
//  mem_addr upper bits [31:WORD_AW] are always 0.
//  Reset mid-RMW: the write is abandoned; Memory ignores wen while reset=0. No response is issued.
// CONFIGURATION
//  MEM_ACCESS_ALIGN_CHECK_EN defined:
//   - Misaligned requests make no memory access (ren/wen stay 0).
//   - rsp_valid=1, rsp_err=1, rsp_rdata=0 on the cycle after accept.
//  Not defined:
//   - Alignment is forced: half ignores addr[0], word ignores addr[1:0].
//   - rsp_err is tied to 0.
// TESTING
//  1. Hold reset=0 -> all outputs 0, req_ready=1. Release -> still idle, no ren/wen pulse.
//  2. sw 0xDEADBEEF @0x100, then lw @0x100.
//     -> wen for 1 cycle at mem_addr=0x40; rdata=0xDEADBEEF 2 cycles after accept.
//  3. Word 0x11223344 @0x100 (BIG_ENDIAN=1), then sb 0xAA @0x101 -> word 0x11AA3344.
//     lb @0x101 -> 0xFFFFFFAA; lbu -> 0x000000AA.
//  4. sh 0x5566 @0x102 -> word 0x11AA5566. lh @0x102 -> 0x00005566; sb latency=3.
//  5. lw @0x102:
//     - with MEM_ACCESS_ALIGN_CHECK_EN -> rsp_err=1, no ren.
//     - without -> reads @0x100, rsp_err=0.
//  6. reset=0 during RMW_WR -> mem_wen falls the same time step, memory unchanged, no rsp_valid.
//     Also check mem_ren&mem_wen==0 throughout all tests.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage load/store initiator for a word-wide memory responder.
//   Takes one load or store at a time from the pipeline and drives the memory
//   port. Byte and halfword loads are lane-extracted and sign/zero extended.
//   Byte and halfword stores are done as read-modify-write. Exactly one
//   response is returned per accepted request.
//
// Optional feature (compile-time macro MEM_ACCESS_ALIGN_CHECK_EN):
//   defined   - misaligned requests make no memory access and return rsp_err=1
//               one cycle after accept.
//   undefined - alignment is forced (low address bits ignored), rsp_err tied 0.
//
// Parameters
//   BIG_ENDIAN  1: byte offset 0 is bits [31:24]; 0: byte offset 0 is bits [7:0]
//   WORD_AW     width of the word index driven on mem_addr
//
// Ports
//   clock, reset          clock (posedge), asynchronous active-low reset
//   req_valid/req_ready   request handshake; ready only while idle
//   req_we                1 = store, 0 = load
//   req_size              0 byte, 1 half, 2/3 word
//   req_signed            sign-extend sub-word load data
//   req_addr, req_wdata   byte address, right-aligned store data
//   rsp_valid             one-cycle response pulse
//   rsp_rdata, rsp_err    extended load data (0 for stores), misaligned flag
//   mem_ren, mem_wen      memory enables, decoded from state (never both 1)
//   mem_addr, mem_din     word index (upper bits 0), write data
//   mem_dout              combinational read data from memory

module mem_access_unit #(
    parameter int BIG_ENDIAN = 1,
    parameter int WORD_AW    = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR} state_t;

    state_t             state;
    logic [WORD_AW+1:0] addr_q;
    logic [1:0]         size_q;
    logic               signed_q;
    logic [31:0]        wdata_q;

    logic [4:0]  lane_shift;
    logic [31:0] lane_mask;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic [31:0] merged;

    // Address bits above the word index never reach the memory.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, req_addr[31:WORD_AW+2]};

    // Enables come straight from the state register, so they cannot glitch
    // and reset drops them in the same time step.
    assign req_ready = (state == IDLE);
    assign mem_ren   = (state == RD) || (state == RMW_RD);
    assign mem_wen   = (state == WR) || (state == RMW_WR);
    assign mem_addr  = {{(32-WORD_AW){1'b0}}, addr_q[WORD_AW+1:2]};

    // Lane position of the latched access within the memory word. Half
    // accesses look only at addr[1], so a misaligned half is forced aligned.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        lane_shift = 5'd0;
        lane_mask  = 32'hFFFF_FFFF;
        if (size_q == 2'd0) begin
            lane_shift = (BIG_ENDIAN != 0) ? {~addr_q[1:0], 3'b000} : {addr_q[1:0], 3'b000};
            lane_mask  = 32'h0000_00FF;
        end else if (size_q == 2'd1) begin
            lane_shift = (BIG_ENDIAN != 0) ? {~addr_q[1], 4'b0000} : {addr_q[1], 4'b0000};
            lane_mask  = 32'h0000_FFFF;
        end
    end

    assign shifted = mem_dout >> lane_shift;

    always_comb begin
        load_data = mem_dout;
        if (size_q == 2'd0)
            load_data = {{24{signed_q & shifted[7]}}, shifted[7:0]};
        else if (size_q == 2'd1)
            load_data = {{16{signed_q & shifted[15]}}, shifted[15:0]};
    end

    // Only the selected lane is replaced; the other bytes come from memory.
    assign merged = (mem_dout & ~(lane_mask << lane_shift)) |
                    ((wdata_q & lane_mask) << lane_shift);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    logic req_mis;
    assign req_mis = ((req_size == 2'd1) & req_addr[0]) |
                     (req_size[1] & (req_addr[1:0] != 2'b00));
    logic err_q;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // NOTE: all state here uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            signed_q  <= 1'b0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            mem_din   <= '0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
            err_q     <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr[WORD_AW+1:0];
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        wdata_q  <= req_wdata;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
                        if (req_mis) begin
                            rsp_valid <= 1'b1;
                            err_q     <= 1'b1;
                            rsp_rdata <= '0;
                        end else
`endif
                        if (!req_we) begin
                            state <= RD;
                        end else if (req_size[1]) begin
                            state   <= WR;
                            mem_din <= req_wdata;
                        end else begin
                            state <= RMW_RD;
                        end
                    end
                end
                RD: begin
                    rsp_rdata <= load_data;
                    rsp_valid <= 1'b1;
                    state     <= IDLE;
                end
                WR: begin
                    rsp_rdata <= '0;
                    rsp_valid <= 1'b1;
                    state     <= IDLE;
                end
                RMW_RD: begin
                    mem_din <= merged;
                    state   <= RMW_WR;
                end
                RMW_WR: begin
                    rsp_rdata <= '0;
                    rsp_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (default parameters, big-endian).
// Includes a behavioural model of the word memory responder.

module tb_mem_access_unit;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    mem_access_unit dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    always #5 clock = ~clock;

    // Memory responder model: combinational read, write commits on the
    // negedge while wen is high, wen ignored during reset.
    logic [31:0] mem [0:1023];
    assign mem_dout = mem[mem_addr[9:0]];
    always @(negedge clock) begin
        if (reset && mem_wen) mem[mem_addr[9:0]] <= mem_din;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nren;
        int          nwen;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[$];

    int          cyc = 0;
    int          ren_cycles = 0;
    int          wen_cycles = 0;
    logic [31:0] last_wen_addr = '0;

    always @(posedge clock) cyc++;

    // Monitor: enable exclusivity, access counting, scoreboard pop.
    always @(negedge clock) begin
        check("ren_wen_excl", {31'd0, mem_ren & mem_wen}, 32'd0);
        if (mem_ren) ren_cycles++;
        if (mem_wen) begin
            wen_cycles++;
            last_wen_addr = mem_addr;
        end
        if (rsp_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check($sformatf("v%0d_rdata", e.id), rsp_rdata, e.rdata);
                check($sformatf("v%0d_err", e.id), {31'd0, rsp_err}, {31'd0, e.err});
                check($sformatf("v%0d_latency", e.id), cyc - e.acc + 1, e.lat);
            end
        end
    end

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic err, input int lat,
                                input int nren, input int nwen);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.err = err; v.lat = lat; v.nren = nren; v.nwen = nwen;
        return v;
    endfunction

    // Called at posedge+1; drives the request, waits for ready, returns
    // at posedge+1 after the accept edge.
    task automatic send(input int id, input vec_t v);
        exp_t e;
        bit   ok = 1'b0;
        req_we = v.we; req_size = v.size; req_signed = v.sgn;
        req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clock);
            if (req_ready) ok = 1'b1;
        end
        if (!ok) begin
            $display("FAIL accept_timeout_v%0d: got no ready expected ready", id);
            $fatal(1, "request never accepted");
        end
        e.id = id; e.rdata = v.rdata; e.err = v.err; e.lat = v.lat; e.acc = cyc + 1;
        sb_q.push_back(e);
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 30 && sb_q.size() != 0; k++) begin
            @(posedge clock);
            #2;
        end
        check(name, sb_q.size(), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        int r0, w0;
        vec_t v;
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        // Stimulus table: memory effects accumulate down the list.
        vecs.push_back(mk(1, 2, 0, 32'h100, 32'hDEADBEEF, 32'h0,        0, 2, 0, 1));
        vecs.push_back(mk(0, 2, 0, 32'h100, 32'h0,       32'hDEADBEEF, 0, 2, 1, 0));
        vecs.push_back(mk(1, 2, 0, 32'h100, 32'h11223344, 32'h0,       0, 2, 0, 1));
        vecs.push_back(mk(1, 0, 0, 32'h101, 32'h123456AA, 32'h0,       0, 3, 1, 1));
        vecs.push_back(mk(0, 2, 0, 32'h100, 32'h0,       32'h11AA3344, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 1, 32'h101, 32'h0,       32'hFFFFFFAA, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h101, 32'h0,       32'h000000AA, 0, 2, 1, 0));
        vecs.push_back(mk(1, 1, 0, 32'h102, 32'hFFFF5566, 32'h0,       0, 3, 1, 1));
        vecs.push_back(mk(0, 2, 0, 32'h100, 32'h0,       32'h11AA5566, 0, 2, 1, 0));
        vecs.push_back(mk(0, 1, 1, 32'h102, 32'h0,       32'h00005566, 0, 2, 1, 0));
        vecs.push_back(mk(0, 1, 0, 32'h100, 32'h0,       32'h000011AA, 0, 2, 1, 0));
        vecs.push_back(mk(1, 2, 0, 32'h104, 32'h8001FF7F, 32'h0,       0, 2, 0, 1));
        vecs.push_back(mk(0, 1, 1, 32'h104, 32'h0,       32'hFFFF8001, 0, 2, 1, 0));
        vecs.push_back(mk(0, 1, 0, 32'h104, 32'h0,       32'h00008001, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 1, 32'h107, 32'h0,       32'h0000007F, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 1, 32'h106, 32'h0,       32'hFFFFFFFF, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h106, 32'h0,       32'h000000FF, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 1, 32'h104, 32'h0,       32'hFFFFFF80, 0, 2, 1, 0));
        vecs.push_back(mk(0, 3, 0, 32'h104, 32'h0,       32'h8001FF7F, 0, 2, 1, 0));
        vecs.push_back(mk(1, 0, 1, 32'h100, 32'h00000099, 32'h0,       0, 3, 1, 1));
        vecs.push_back(mk(1, 0, 0, 32'h103, 32'h00000077, 32'h0,       0, 3, 1, 1));
        vecs.push_back(mk(0, 2, 0, 32'h100, 32'h0,       32'h99AA5577, 0, 2, 1, 0));
        vecs.push_back(mk(0, 1, 1, 32'h100, 32'h0,       32'hFFFF99AA, 0, 2, 1, 0));
        // Misaligned cases: error response without access, or forced alignment.
        vecs.push_back(ALIGN ? mk(0, 2, 0, 32'h102, 32'h0, 32'h0, 1, 1, 0, 0)
                             : mk(0, 2, 0, 32'h102, 32'h0, 32'h99AA5577, 0, 2, 1, 0));
        vecs.push_back(ALIGN ? mk(0, 1, 0, 32'h101, 32'h0, 32'h0, 1, 1, 0, 0)
                             : mk(0, 1, 0, 32'h101, 32'h0, 32'h000099AA, 0, 2, 1, 0));
        vecs.push_back(ALIGN ? mk(1, 2, 0, 32'h106, 32'hCAFEF00D, 32'h0, 1, 1, 0, 0)
                             : mk(1, 2, 0, 32'h106, 32'hCAFEF00D, 32'h0, 0, 2, 0, 1));
        vecs.push_back(mk(0, 2, 0, 32'h104, 32'h0, ALIGN ? 32'h8001FF7F : 32'hCAFEF00D, 0, 2, 1, 0));
        vecs.push_back(ALIGN ? mk(1, 1, 1, 32'h105, 32'h0000BEEF, 32'h0, 1, 1, 0, 0)
                             : mk(1, 1, 1, 32'h105, 32'h0000BEEF, 32'h0, 0, 3, 1, 1));
        vecs.push_back(mk(0, 2, 0, 32'h104, 32'h0, ALIGN ? 32'h8001FF7F : 32'hBEEFF00D, 0, 2, 1, 0));

        // Reset held: everything idle and zero.
        repeat (2) @(posedge clock);
        #1;
        check("rst_flags", {27'd0, rsp_valid, rsp_err, mem_ren, mem_wen, req_ready}, 32'd1);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_din", mem_din, 32'd0);
        @(negedge clock);
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("post_rst_no_access", ren_cycles + wen_cycles, 32'd0);
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);

        // Table-driven vectors.
        foreach (vecs[i]) begin
            r0 = ren_cycles;
            w0 = wen_cycles;
            send(i, vecs[i]);
            wait_done($sformatf("v%0d_drain", i));
            check($sformatf("v%0d_ren_cycles", i), ren_cycles - r0, vecs[i].nren);
            check($sformatf("v%0d_wen_cycles", i), wen_cycles - w0, vecs[i].nwen);
            if (i == 0) check("sw_mem_addr", last_wen_addr, 32'h40);
        end
        check("mem_word_100", mem[32'h40], 32'h99AA5577);

        // Back-to-back loads: the second is accepted in the response cycle.
        send(100, mk(0, 2, 0, 32'h100, 32'h0, 32'h99AA5577, 0, 2, 1, 0));
        send(101, mk(0, 2, 0, 32'h104, 32'h0, ALIGN ? 32'h8001FF7F : 32'hBEEFF00D, 0, 2, 1, 0));
        wait_done("b2b_drain");

        // Reset during RMW_WR: write abandoned, no response.
        send(200, mk(1, 2, 0, 32'h108, 32'h01020304, 32'h0, 0, 2, 0, 1));
        wait_done("rmw_pre_drain");
        send(201, mk(1, 0, 0, 32'h109, 32'h000000EE, 32'h0, 0, 3, 1, 1));
        @(negedge clock);
        check("rmw_rd_ren", {31'd0, mem_ren}, 32'd1);
        @(posedge clock);
        #1;
        check("rmw_wr_wen", {31'd0, mem_wen}, 32'd1);
        reset = 1'b0;
        #1;
        check("rmw_rst_flags", {28'd0, mem_wen, mem_ren, rsp_valid, req_ready}, 32'd1);
        sb_q.delete();
        @(negedge clock);
        @(negedge clock);
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rmw_mem_unchanged", mem[32'h42], 32'h01020304);
        v = mk(0, 2, 0, 32'h108, 32'h0, 32'h01020304, 0, 2, 1, 0);
        send(202, v);
        wait_done("rmw_post_drain");

        repeat (2) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
